// File: rtl/tx_frame_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// tx_sched_pkg
// Shared constants and types for the link-frame scheduler.
//   FRAME_WORDS   word slots per link frame; the last slot carries the trailer
//   BX_PER_FRAME  bunch crossings covered by one frame (bcid step per frame)
//   BCID_MAX      bcid modulus (one LHC orbit)
//   FILL_WORD     idle word for data slots that carry no requester data
//   TRAILER_TAG   top nibble of the trailer word
//   sched_state_t scheduler FSM states
//   next_bcid()   bcid of the following frame, wrapping at BCID_MAX
// ----------------------------------------------------------------------------
package tx_sched_pkg;

    localparam int          FRAME_WORDS  = 24;
    localparam int          BX_PER_FRAME = 4;
    localparam int          BCID_MAX     = 3564;
    localparam logic [23:0] FILL_WORD    = 24'hBC0000;
    localparam logic [3:0]  TRAILER_TAG  = 4'hF;
    localparam int          SLOT_W       = $clog2(FRAME_WORDS);

    typedef enum logic {
        ST_WAIT_BC0 = 1'b0,
        ST_RUN      = 1'b1
    } sched_state_t;

    // Flywheel step: BCID_MAX is a multiple of BX_PER_FRAME, so the sum lands
    // exactly on BCID_MAX at the end of an orbit.
    function automatic logic [11:0] next_bcid(input logic [11:0] bcid);
        logic [12:0] sum;
        sum = {1'b0, bcid} + 13'(BX_PER_FRAME);
        return (sum >= 13'(BCID_MAX)) ? 12'd0 : sum[11:0];
    endfunction

endpackage

// File: rtl/tx_frame_scheduler_if.sv
// ----------------------------------------------------------------------------
// tx_frame_scheduler_if
// Requester streams into the scheduler and the word/sideband stream out to
// the tx_protocol_wrapper.
//   req_data_i     NREQ*24  requester words, requester i on [24*i+23:24*i]
//   req_valid_i    NREQ     requester word valid
//   req_ready_o    NREQ     one-hot grant
//   tx_user_word_o 24       slot word to the wrapper
//   bc0_o          1        orbit marker to the wrapper
//   bcid_o         12       frame bcid to the wrapper
// Handshake: a word moves when valid and ready are both high on a rising
// clock edge. Ready may depend combinationally on valid; valid must not depend
// on ready. A requester holding valid without ready keeps its data stable.
// ----------------------------------------------------------------------------
interface tx_frame_scheduler_if #(
    parameter int NREQ = 4
);
    logic [NREQ*24-1:0] req_data_i;
    logic [NREQ-1:0]    req_valid_i;
    logic [NREQ-1:0]    req_ready_o;
    logic [23:0]        tx_user_word_o;
    logic               bc0_o;
    logic [11:0]        bcid_o;

    // scheduler side
    modport slave (
        input  req_data_i, req_valid_i,
        output req_ready_o, tx_user_word_o, bc0_o, bcid_o
    );

    // requester / wrapper side
    modport master (
        output req_data_i, req_valid_i,
        input  req_ready_o, tx_user_word_o, bc0_o, bcid_o
    );
endinterface

// File: rtl/tx_frame_scheduler_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter: the first requester found searching
// upward from ptr (wrapping) is granted.
//   req_i    N    request vector
//   ptr_i    PW   search start index
//   grant_o  N    one-hot grant (all zero when no request)
//   any_o    1    some requester granted
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic          any_o
);
    logic [PW-1:0] w_idx;
    logic          w_found;

    always_comb begin
        grant_o = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < N; i++) begin
            w_idx = PW'((int'(ptr_i) + i) % N);
            if (!w_found && req_i[w_idx]) begin
                grant_o[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

    assign any_o = w_found;
endmodule

// File: rtl/tx_frame_scheduler.sv
// ----------------------------------------------------------------------------
// tx_frame_scheduler
// Shares each link frame among NREQ requester streams by round-robin, fills
// idle data slots, appends a trailer and produces the bc0/bcid sideband kept
// in step with the TTC orbit marker.
//   clk240_i        link clock
//   rst_i           synchronous active-high reset
//   enable_i        0: no grants, every data slot carries FILL_WORD
//   en_mask_i       per-requester enable
//   ttc_bc0_i       one-cycle orbit marker from TTC
//   bus             requester streams in, word/bc0/bcid out (slave modport)
//   locked_o        frame has been aligned to ttc_bc0_i since reset
//   misalign_cnt_o  unexpected ttc_bc0_i count, saturating
//   state_o         FSM state (debug)
// ----------------------------------------------------------------------------
module tx_frame_scheduler
    import tx_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                  clk240_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic [NREQ-1:0]       en_mask_i,
    input  logic                  ttc_bc0_i,
    tx_frame_scheduler_if.slave   bus,
    output logic                  locked_o,
    output logic [15:0]           misalign_cnt_o,
    output sched_state_t          state_o
);
    localparam int                PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_WORDS - 1);

    sched_state_t      r_state, w_state_nxt;
    logic [SLOT_W-1:0] r_slot;
    logic [11:0]       r_bcid;
    logic [PW-1:0]     r_ptr;
    logic [7:0]        r_count;
    logic [23:0]       r_word;
    logic              r_bc0;
    logic [11:0]       r_bcid_out;
    logic              r_locked;
    logic [15:0]       r_misalign;

    logic              w_is_trailer;
    logic [NREQ-1:0]   w_arb_req;
    logic [NREQ-1:0]   w_grant;
    logic              w_any;
    logic [NREQ-1:0]   w_ready;
    logic [23:0]       w_slot_word;
    logic [PW-1:0]     w_gnt_idx;
    logic              w_expected_bc0;
    logic              w_realign;

    assign w_is_trailer = (r_slot == LAST_SLOT);

    // Only data slots in RUN are offered to the arbiter, so any grant is a transfer.
    assign w_arb_req = (r_state == ST_RUN && !w_is_trailer)
                     ? (bus.req_valid_i & en_mask_i & {NREQ{enable_i}}) : '0;

    rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
        .req_i   (w_arb_req),
        .ptr_i   (r_ptr),
        .grant_o (w_grant),
        .any_o   (w_any)
    );

    // A TTC marker on the last slot of the orbit's last frame agrees with the flywheel.
    assign w_expected_bc0 = w_is_trailer && (next_bcid(r_bcid) == 12'd0);
    assign w_realign      = ttc_bc0_i && (r_state == ST_RUN) && !w_expected_bc0;

    always_ff @(posedge clk240_i) begin
        if (rst_i) r_state <= ST_WAIT_BC0;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = '0;
        w_slot_word = FILL_WORD;
        w_gnt_idx   = '0;
        case (r_state)
            ST_WAIT_BC0: begin
                if (ttc_bc0_i) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_is_trailer) begin
                    w_slot_word = {TRAILER_TAG, r_count, r_bcid};
                end else if (w_any) begin
                    w_ready = w_grant;
                    for (int i = 0; i < NREQ; i++) begin
                        if (w_grant[i]) begin
                            w_gnt_idx   = PW'(i);
                            w_slot_word = bus.req_data_i[24*i +: 24];
                        end
                    end
                end
            end
            default: w_state_nxt = ST_WAIT_BC0;
        endcase
    end

    always_ff @(posedge clk240_i) begin
        if (rst_i) begin
            r_slot     <= '0;
            r_bcid     <= '0;
            r_ptr      <= '0;
            r_count    <= '0;
            r_word     <= FILL_WORD;
            r_bc0      <= 1'b0;
            r_bcid_out <= '0;
            r_locked   <= 1'b0;
            r_misalign <= '0;
        end else begin
            // Output stage: one cycle behind the slot being built.
            r_word     <= w_slot_word;
            r_bcid_out <= r_bcid;
            r_bc0      <= (r_state == ST_RUN) && (r_slot == '0) && (r_bcid == 12'd0);
            if (ttc_bc0_i) r_locked <= 1'b1;

            if (r_state == ST_WAIT_BC0) begin
                if (ttc_bc0_i) begin
                    r_slot  <= '0;
                    r_bcid  <= '0;
                    r_count <= '0;
                end
            end else begin
                if (w_realign) begin
                    // The partial frame is dropped without a trailer.
                    r_slot  <= '0;
                    r_bcid  <= '0;
                    r_count <= '0;
                    if (r_misalign != 16'hFFFF) r_misalign <= r_misalign + 16'd1;
                end else if (w_is_trailer) begin
                    r_slot  <= '0;
                    r_bcid  <= next_bcid(r_bcid);
                    r_count <= '0;
                end else begin
                    r_slot <= r_slot + 1'b1;
                    if (w_any) r_count <= r_count + 8'd1;
                end
                if (w_any) r_ptr <= (w_gnt_idx == PW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
            end
        end
    end

    assign bus.req_ready_o    = w_ready;
    assign bus.tx_user_word_o = r_word;
    assign bus.bc0_o          = r_bc0;
    assign bus.bcid_o         = r_bcid_out;
    assign locked_o           = r_locked;
    assign misalign_cnt_o     = r_misalign;
    assign state_o            = r_state;
endmodule
